ysyx_25030093_sram_arbiter: RTL and testbench

YSYX_25030093_SRAM_ARBITER -- requirements
Module: ysyx_25030093_sram_arbiter

---
 rtl/ysyx_25030093_arb_pkg.sv | 29 ++
 rtl/ysyx_25030093_arb_pick.sv | 42 ++++
 rtl/ysyx_25030093_sram_arbiter.sv | 139 +++++++++++++
 tb/tb_ysyx_25030093_sram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030093_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_25030093_arb_pkg                                      |
// | Brief   : Shared types and defaults for the IFU/LSU SRAM arbiter.    |
// | Config  : YSYX_25030093_ARB_RR_EN selects round-robin arbitration.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package ysyx_25030093_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_IFU = 0;
   localparam int GNT_LSU = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_25030093_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_25030093_arb_pick                                     |
// | Brief   : Two-way winner selection, one-hot grant output.            |
// | Config  : YSYX_25030093_ARB_RR_EN -> favour the requester not        |
// |           granted last; otherwise the LSU wins every tie.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ysyx_25030093_arb_pick
   import ysyx_25030093_arb_pkg::*;
(
   input  logic       ifu_valid,
   input  logic       lsu_valid,
   input  owner_t     last_grant,
   output logic [1:0] grant
);

`ifndef YSYX_25030093_ARB_RR_EN
   // Fixed priority has no history; the input is kept for a uniform interface
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // Select at most one winner; ties resolved by the configured policy
   always_comb begin
      grant = 2'b00;
      if (ifu_valid && lsu_valid) begin
`ifdef YSYX_25030093_ARB_RR_EN
         grant[GNT_IFU] = (last_grant == OWN_LSU);
         grant[GNT_LSU] = (last_grant == OWN_IFU);
`else
         grant[GNT_LSU] = 1'b1;
`endif
      end else if (ifu_valid) begin
         grant[GNT_IFU] = 1'b1;
      end else if (lsu_valid) begin
         grant[GNT_LSU] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_25030093_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_25030093_sram_arbiter                                 |
// | Brief   : Shares one SRAM port between IFU and LSU, one transaction  |
// |           in flight (IDLE -> SEND -> WAIT -> IDLE).                  |
// | Config  : YSYX_25030093_ARB_RR_EN enables round-robin tie breaking.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ysyx_25030093_sram_arbiter
   import ysyx_25030093_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch port
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   // load/store port
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   // shared SRAM port
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_t     state;
   owner_t     owner;
   owner_t     last_grant;
   logic [1:0] grant;
   logic       in_idle;
   logic       ifu_sel;
   logic       lsu_sel;

   ysyx_25030093_arb_pick u_pick (
      .ifu_valid  (ifu_req_valid),
      .lsu_valid  (lsu_req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Handshakes only open in IDLE; gating with rst keeps ready low while reset is held
   assign in_idle       = rst && (state == IDLE);
   assign ifu_req_ready = in_idle && grant[GNT_IFU];
   assign lsu_req_ready = in_idle && grant[GNT_LSU];

   // Response path is a straight passthrough to the owner while waiting
   assign ifu_sel        = (state == WAIT) && (owner == OWN_IFU);
   assign lsu_sel        = (state == WAIT) && (owner == OWN_LSU);
   assign ifu_resp_valid = ifu_sel && mem_resp_valid;
   assign lsu_resp_valid = lsu_sel && mem_resp_valid;
   assign ifu_rdata      = ifu_sel ? mem_rdata : '0;
   assign lsu_rdata      = lsu_sel ? mem_rdata : '0;
   assign mem_resp_ready = (ifu_sel && ifu_resp_ready) || (lsu_sel && lsu_resp_ready);

`ifdef YSYX_25030093_ARB_RR_EN
   // Remember who won the most recent grant for the next tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= OWN_LSU;
      end else if ((state == IDLE) && (grant != 2'b00)) begin
         last_grant <= grant[GNT_LSU] ? OWN_LSU : OWN_IFU;
      end
   end
`else
   assign last_grant = OWN_LSU;
`endif

   // Transaction FSM with registered request payload and request valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= OWN_IFU;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  state         <= SEND;
                  mem_req_valid <= 1'b1;
                  if (grant[GNT_LSU]) begin
                     owner     <= OWN_LSU;
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     owner     <= OWN_IFU;
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
               end
            end
            SEND: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid && mem_resp_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               mem_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030093_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ysyx_25030093_sram_arbiter                              |
// | Brief   : Directed self-checking bench for the SRAM arbiter.         |
// | Config  : YSYX_25030093_ARB_RR_EN adds the round-robin sequence.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_ysyx_25030093_sram_arbiter;

`ifdef YSYX_25030093_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
   logic [31:0] ifu_addr = '0, ifu_rdata;
   logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
   logic [3:0]  lsu_wmask = '0;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0, mem_resp_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wmask;

   int n_checks = 0;
   int n_fail   = 0;
   bit last_lsu = 1'b1;

   always #5 clk = ~clk;

   ysyx_25030093_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE with valids already driven
   task automatic grant(input bit exp_lsu, input bit drop);
      #1;
      check("grant.ifu_req_ready", ifu_req_ready, !exp_lsu);
      check("grant.lsu_req_ready", lsu_req_ready, exp_lsu);
      last_lsu = exp_lsu;
      @(negedge clk);
      if (drop) begin
         if (exp_lsu) lsu_req_valid = 1'b0;
         else         ifu_req_valid = 1'b0;
      end
   endtask

   // Runs SEND and WAIT phases of one transaction, ending at a negedge in IDLE
   task automatic txn(input bit own_lsu, input logic [31:0] addr, input bit wen,
                      input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] rdata,
                      input int req_stall, input int resp_lat, input int rdy_stall);
      for (int i = 0; i <= req_stall; i++) begin
         mem_req_ready  = (i == req_stall);
         mem_resp_valid = (i == 0);
         mem_rdata      = 32'hBAD0_0000;
         #1;
         check("send.mem_req_valid", mem_req_valid, 1);
         check("send.mem_addr", mem_addr, addr);
         check("send.mem_wen", mem_wen, wen);
         check("send.mem_wdata", mem_wdata, wdata);
         check("send.mem_wmask", mem_wmask, wmask);
         check("send.req_ready", {ifu_req_ready, lsu_req_ready}, 0);
         check("send.mem_resp_ready", mem_resp_ready, 0);
         check("send.resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
         @(negedge clk);
      end
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      for (int i = 0; i < resp_lat; i++) begin
         #1;
         check("wait.mem_req_valid", mem_req_valid, 0);
         check("wait.resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
         @(negedge clk);
      end
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      for (int i = 0; i <= rdy_stall; i++) begin
         ifu_resp_ready = own_lsu ? 1'b1 : (i == rdy_stall);
         lsu_resp_ready = own_lsu ? (i == rdy_stall) : 1'b1;
         #1;
         check("wait.owner_resp_valid", own_lsu ? lsu_resp_valid : ifu_resp_valid, 1);
         check("wait.other_resp_valid", own_lsu ? ifu_resp_valid : lsu_resp_valid, 0);
         check("wait.mem_resp_ready", mem_resp_ready, (i == rdy_stall));
         if (!wen) check("wait.rdata", own_lsu ? lsu_rdata : ifu_rdata, rdata);
         @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      ifu_resp_ready = 1'b0;
      lsu_resp_ready = 1'b0;
      #1;
      check("idle.resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
      check("idle.mem_req_valid", mem_req_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, including a request held during reset
      ifu_req_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst.req_ready", {ifu_req_ready, lsu_req_ready}, 0);
      check("rst.mem_req_valid", mem_req_valid, 0);
      check("rst.mem_addr", mem_addr, 0);
      check("rst.mem_wen_wmask", {mem_wen, mem_wmask}, 0);
      check("rst.mem_wdata", mem_wdata, 0);
      check("rst.resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 0);
      ifu_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Stray memory response in IDLE is ignored
      mem_resp_valid = 1'b1;
      ifu_resp_ready = 1'b1;
      #1;
      check("idle.stray.mem_resp_ready", mem_resp_ready, 0);
      check("idle.stray.resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      ifu_resp_ready = 1'b0;
      #1;
      check("idle.stray.no_grant", mem_req_valid, 0);

      // IFU alone, response after two wait cycles
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0000;
      grant(1'b0, 1'b1);
      txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0, 2, 0);

      // Simultaneous IFU fetch and LSU store, SEND stalled 5 cycles
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0004;
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_1000;
      lsu_wen       = 1'b1;
      lsu_wdata     = 32'hDEAD_BEEF;
      lsu_wmask     = 4'hF;
      grant(RR ? !last_lsu : 1'b1, 1'b1);
      txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 5, 1, 0);

      // Pending IFU served next, requester withholds resp_ready 3 cycles
      grant(1'b0, 1'b1);
      txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0010_0093, 0, 1, 3);

`ifdef YSYX_25030093_ARB_RR_EN
      // Both requesting continuously: expect LSU, IFU, LSU, IFU, LSU, IFU
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0100;
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_2100;
      lsu_wen       = 1'b0;
      lsu_wmask     = 4'h3;
      lsu_wdata     = 32'h1111_2222;
      for (int k = 0; k < 6; k++) begin
         grant((k % 2) == 0, 1'b0);
         if ((k % 2) == 0)
            txn(1'b1, 32'h8000_2100, 1'b0, 32'h1111_2222, 4'h3, 32'hA000_0000 + k, 0, 0, 0);
         else
            txn(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'hB000_0000 + k, 0, 0, 0);
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      @(negedge clk);
`endif

      // LSU load alone
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_2000;
      lsu_wen       = 1'b0;
      lsu_wdata     = 32'h5555_AAAA;
      lsu_wmask     = 4'h1;
      grant(1'b1, 1'b1);
      txn(1'b1, 32'h8000_2000, 1'b0, 32'h5555_AAAA, 4'h1, 32'hCAFE_F00D, 0, 0, 0);

      // Reset asserted in WAIT with a response on the bus
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0010;
      grant(1'b0, 1'b1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h1234_5678;
      ifu_resp_ready = 1'b1;
      #1;
      check("prerst.ifu_resp_valid", ifu_resp_valid, 1);
      rst = 1'b0;
      #1;
      check("midrst.resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 0);
      check("midrst.mem_req_valid", mem_req_valid, 0);
      check("midrst.mem_addr", mem_addr, 0);
      check("midrst.ifu_rdata", ifu_rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      last_lsu = 1'b1;
      #1;
      check("postrst.resp", {ifu_resp_valid, mem_resp_ready}, 0);
      mem_resp_valid = 1'b0;
      ifu_resp_ready = 1'b0;
      ifu_req_valid  = 1'b1;
      ifu_addr       = 32'h8000_0020;
      grant(1'b0, 1'b1);
      txn(1'b0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
